// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming KxK / stride-K signed max-pool over a row-major
// pixel stream, CHANNELS lanes side by side, one pixel per clock, no stall.
// The horizontal max is kept in a per-lane register. The vertical max across
// window rows is kept in a line buffer with one entry per output column.
// Optional build macro POOL_RELU_EN clamps negative pooled outputs to zero.
// The clamp is applied at the output register only.

// Per-lane datapath: running horizontal max, merge with the line buffer, optional clamp.
module maxpool_lane #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] px,
    input  logic signed [DATA_W-1:0] h_max,
    input  logic signed [DATA_W-1:0] lb_val,
    input  logic                     first_col,
    input  logic                     first_row,
    output logic signed [DATA_W-1:0] h_next,
    output logic signed [DATA_W-1:0] win_max,
    output logic signed [DATA_W-1:0] pooled
);
    // A new window row restarts the horizontal max.
    assign h_next  = (first_col || (px > h_max)) ? px : h_max;
    // The first window row overwrites the stale line-buffer entry.
    assign win_max = (first_row || (h_next > lb_val)) ? h_next : lb_val;
`ifdef POOL_RELU_EN
    assign pooled  = win_max[DATA_W-1] ? '0 : win_max;
`else
    assign pooled  = win_max;
`endif
endmodule

module maxpool_stream #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 4,
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24,
    parameter int K        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    output logic                         valid_out,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic                         last_out
);
    // K is guarded so that an illegal K still elaborates far enough to reach the error below.
    localparam int KS  = (K < 1) ? 1 : K;
    localparam int OW  = IMG_W / KS;
    localparam int OH  = IMG_H / KS;
    localparam int KXW = (KS > 1) ? $clog2(KS) : 1;
    localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
    localparam int ORW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [KXW-1:0] K_LAST  = KXW'(KS - 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(OW - 1);
    localparam logic [ORW-1:0] OR_LAST = ORW'(OH - 1);

    if (K < 1 || (IMG_W % KS) != 0 || (IMG_H % KS) != 0) begin : g_bad_cfg
        $error("maxpool_stream: K must be >= 1 and divide IMG_W and IMG_H");
    end

    logic [KXW-1:0] kx, ky;
    logic [OCW-1:0] oc;
    logic [ORW-1:0] orow;

    logic [CHANNELS-1:0][DATA_W-1:0] px, h_max, h_next, win_max, pooled, lb_rd;
    logic [CHANNELS*DATA_W-1:0]      lb [OW];

    logic first_col, first_row, win_done, out_fire, frame_end;

    assign px        = data_in;
    assign lb_rd     = lb[oc];
    assign first_col = (kx == '0);
    assign first_row = (ky == '0);
    assign win_done  = valid_in && (kx == K_LAST);
    assign out_fire  = win_done && (ky == K_LAST);
    assign frame_end = (oc == OC_LAST) && (orow == OR_LAST);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        maxpool_lane #(.DATA_W(DATA_W)) u_lane (
            .px        (px[c]),
            .h_max     (h_max[c]),
            .lb_val    (lb_rd[c]),
            .first_col (first_col),
            .first_row (first_row),
            .h_next    (h_next[c]),
            .win_max   (win_max[c]),
            .pooled    (pooled[c])
        );
    end

    // Window/column/row counters, horizontal max and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            kx        <= '0;
            ky        <= '0;
            oc        <= '0;
            orow      <= '0;
            h_max     <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (valid_in) begin
                h_max <= h_next;
                if (kx == K_LAST) begin
                    kx <= '0;
                    if (oc == OC_LAST) begin
                        oc <= '0;
                        if (ky == K_LAST) begin
                            ky   <= '0;
                            orow <= (orow == OR_LAST) ? '0 : orow + 1'b1;
                        end else begin
                            ky <= ky + 1'b1;
                        end
                    end else begin
                        oc <= oc + 1'b1;
                    end
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            if (out_fire) begin
                valid_out <= 1'b1;
                last_out  <= frame_end;
                data_out  <= pooled;
            end
        end
    end

    // Line buffer keeps unclamped partial column maxima. It is not reset.
    // The first window row overwrites whatever is in the buffer.
    always_ff @(posedge clk) begin
        if (!rst && win_done && (ky != K_LAST))
            lb[oc] <= win_max;
    end
endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream.
// DUT a uses K=2 on a 4x4 frame with 1 lane. DUT b uses K=3 on a 3x3 frame with 2 lanes.
module tb_maxpool_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_vin = 1'b0;
    logic [15:0] a_din = '0;
    logic        a_vout, a_last;
    logic [15:0] a_dout;

    logic        b_vin = 1'b0;
    logic [31:0] b_din = '0;
    logic        b_vout, b_last;
    logic [31:0] b_dout;

    maxpool_stream #(.DATA_W(16), .CHANNELS(1), .IMG_W(4), .IMG_H(4), .K(2)) u_dut_a (
        .clk(clk), .rst(rst), .valid_in(a_vin), .data_in(a_din),
        .valid_out(a_vout), .data_out(a_dout), .last_out(a_last)
    );

    maxpool_stream #(.DATA_W(16), .CHANNELS(2), .IMG_W(3), .IMG_H(3), .K(3)) u_dut_b (
        .clk(clk), .rst(rst), .valid_in(b_vin), .data_in(b_din),
        .valid_out(b_vout), .data_out(b_dout), .last_out(b_last)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        qa[$], qb[$];
    exp_t        ea, eb;
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [15:0] a_hold = '0;
    int          fa [16];
    int          pa = 0;

    int F1 [16] = '{1, 5, -3, 2,   4, 0, -7, -1,   9, 9, 9, 9,   9, 9, 9, 9};
    int FN [16] = '{-8, -3, -8, -3,   -5, -9, -5, -9,   -8, -3, -8, -3,   -5, -9, -5, -9};
    int FM [16] = '{-32768, -32768, 100, 100,   -32768, -32768, 100, 100,
                    -32768, 32767, -1, -32768,  -32768, -32768, -32768, -1};

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one pixel into DUT a. When it completes a window, push the window max.
    task automatic drive_a(input int v);
        exp_t e;
        int   r, c, m;
        @(negedge clk);
        a_vin = 1'b1;
        a_din = 16'(v);
        fa[pa] = v;
        r = pa / 4;
        c = pa % 4;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = fa[(r-1)*4 + c-1];
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++)
                    if (fa[(r-dr)*4 + c-dc] > m) m = fa[(r-dr)*4 + c-dc];
`ifdef POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            e.data = {16'h0, 16'(m)};
            e.last = (pa == 15);
            e.cyc  = cyc + 1;
            qa.push_back(e);
        end
        pa = (pa + 1) % 16;
    endtask

    task automatic drive_b(input int idx);
        exp_t e;
        @(negedge clk);
        b_vin = 1'b1;
        b_din = {16'(-idx), 16'(idx)};
        if (idx == 8) begin
            e.data = {16'h0000, 16'd8};
            e.last = 1'b1;
            e.cyc  = cyc + 1;
            qb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_vin = 1'b0;
            b_vin = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_vin = 1'b0;
        b_vin = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        pa     = 0;
        a_hold = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard for DUT a: pooled outputs, cycle timing, last flag and data hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_vout) begin
                if (qa.size() == 0) begin
                    chk("a_spurious_valid", 32'(a_vout), 32'(0));
                end else begin
                    ea = qa.pop_front();
                    chk("a_data",  {16'h0, a_dout}, ea.data);
                    chk("a_last",  32'(a_last), 32'(ea.last));
                    chk("a_cycle", 32'(cyc), 32'(ea.cyc));
                    a_hold = a_dout;
                end
            end else begin
                chk("a_last_idle", 32'(a_last), 32'(0));
                chk("a_hold", {16'h0, a_dout}, {16'h0, a_hold});
            end
        end
    end

    // Scoreboard for DUT b.
    always @(negedge clk) begin
        if (mon_en && b_vout) begin
            if (qb.size() == 0) begin
                chk("b_spurious_valid", 32'(b_vout), 32'(0));
            end else begin
                eb = qb.pop_front();
                chk("b_data",  b_dout, eb.data);
                chk("b_last",  32'(b_last), 32'(eb.last));
                chk("b_cycle", 32'(cyc), 32'(eb.cyc));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_a_valid", 32'(a_vout), 32'(0));
        chk("rst_a_last",  32'(a_last), 32'(0));
        chk("rst_a_data",  {16'h0, a_dout}, 32'(0));
        chk("rst_b_valid", 32'(b_vout), 32'(0));
        chk("rst_b_data",  b_dout, 32'(0));
        rst    = 1'b0;
        mon_en = 1'b1;

        // continuous frame
        for (int i = 0; i < 16; i++) drive_a(F1[i]);
        idle(2);
        // same frame with 3 idle cycles between pixels
        for (int i = 0; i < 16; i++) begin
            drive_a(F1[i]);
            idle(3);
        end
        // all-negative frame
        for (int i = 0; i < 16; i++) drive_a(FN[i]);
        idle(2);
        // reset after 6 pixels, then a full frame
        for (int i = 0; i < 6; i++) drive_a(F1[i]);
        do_reset();
        for (int i = 0; i < 16; i++) drive_a(F1[i]);
        idle(2);
        // back-to-back frames, second all 7
        for (int i = 0; i < 16; i++) drive_a(F1[i]);
        for (int i = 0; i < 16; i++) drive_a(7);
        idle(2);
        // extreme values and ties
        for (int i = 0; i < 16; i++) drive_a(FM[i]);
        idle(2);
        // random frames with random gaps
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 16; i++) begin
                drive_a(int'($urandom_range(0, 65535)) - 32768);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        idle(2);
        // K=3, two lanes
        for (int i = 0; i < 9; i++) drive_b(i);
        idle(3);

        chk("a_drain", 32'(qa.size()), 32'(0));
        chk("b_drain", 32'(qb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
